// File: rtl/ifft_frame_feeder_pkg.sv
// Shared constants and types for the IFFT frame feeder.
// Complex samples are {imag, real} and are never modified.
package ifft_frame_feeder_pkg;

  localparam int unsigned BinW  = 11;
  localparam int unsigned DataW = 48;

  localparam int unsigned ReLsb = 0;
  localparam int unsigned ReMsb = 23;
  localparam int unsigned ImLsb = 24;
  localparam int unsigned ImMsb = 47;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankDraining
  } bank_state_e;

endpackage

// File: rtl/ifft_frame_feeder_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, bin index}; no reset so it maps onto block RAM.
module frame_bank_ram #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned DataW = 48
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [2**AddrW];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifft_frame_feeder.sv
// Ping-pong frame buffer between the spectral resampler and the IFFT core.
// Frames are captured by bin index and streamed out in ascending bin order.
module ifft_frame_feeder
  import ifft_frame_feeder_pkg::*;
#(
  parameter int unsigned WIDTH  = BinW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WIDTH-1:0]  in_k,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [WIDTH-1:0]  m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [1:0]        frames_held,
  output logic              err_overflow,
  output logic              err_len
);

  localparam logic [WIDTH-1:0] LastBin = {WIDTH{1'b1}};

  typedef struct packed {
    logic              last;
    logic [WIDTH-1:0]  user;
    logic [DATA_W-1:0] data;
  } beat_t;

  bank_state_e [1:0] state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              iss_bank_q, iss_bank_d;
  logic              iss_busy_q, iss_busy_d;
  logic [WIDTH-1:0]  iss_addr_q, iss_addr_d;
  logic              rd_vld_q;
  logic [WIDTH-1:0]  rd_user_q;
  beat_t             ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_len_q, err_len_d;

  logic              wr_ok, wr_en, pop, push, iss_ok, iss_en;
  logic [2:0]        occ;
  logic [DATA_W-1:0] ram_rdata;
  beat_t             new_beat;

  assign wr_ok  = (state_q[wr_bank_q] == BankEmpty) || (state_q[wr_bank_q] == BankFilling);
  assign wr_en  = in_valid && wr_ok;
  assign pop    = (cnt_q != 2'd0) && m_tready;
  assign push   = rd_vld_q;
  assign iss_ok = iss_busy_q || (state_q[iss_bank_q] == BankFull);
  // Reads in flight plus buffered beats never exceed the two skid entries.
  assign occ    = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign iss_en = iss_ok && (occ < 3'd2);

  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    beat_cnt_d     = beat_cnt_q;
    rd_bank_d      = rd_bank_q;
    iss_bank_d     = iss_bank_q;
    iss_busy_d     = iss_busy_q;
    iss_addr_d     = iss_addr_q;
    err_overflow_d = err_overflow_q;
    err_len_d      = err_len_q;

    if (wr_en) begin
      if (in_last) begin
        state_d[wr_bank_q] = BankFull;
        wr_bank_d          = ~wr_bank_q;
        beat_cnt_d         = '0;
        if (beat_cnt_q != LastBin) begin
          err_len_d = 1'b1;
        end
      end else begin
        state_d[wr_bank_q] = BankFilling;
        beat_cnt_d         = beat_cnt_q + 1'b1;
      end
    end
    if (in_valid && !wr_ok) begin
      err_overflow_d = 1'b1;
    end

    // The issue pointer runs ahead of rd_bank so the next frame follows without a gap.
    if (iss_en) begin
      if (!iss_busy_q) begin
        state_d[iss_bank_q] = BankDraining;
      end
      if (iss_addr_q == LastBin) begin
        iss_busy_d = 1'b0;
        iss_bank_d = ~iss_bank_q;
        iss_addr_d = '0;
      end else begin
        iss_busy_d = 1'b1;
        iss_addr_d = iss_addr_q + 1'b1;
      end
    end

    if (pop && ent0_q.last) begin
      state_d[rd_bank_q] = BankEmpty;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  assign new_beat = '{last: (rd_user_q == LastBin), user: rd_user_q, data: ram_rdata};

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = new_beat;
        end else begin
          ent1_d = new_beat;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_beat;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BankEmpty;
      end
      wr_bank_q      <= 1'b0;
      beat_cnt_q     <= '0;
      rd_bank_q      <= 1'b0;
      iss_bank_q     <= 1'b0;
      iss_busy_q     <= 1'b0;
      iss_addr_q     <= '0;
      rd_vld_q       <= 1'b0;
      rd_user_q      <= '0;
      ent0_q         <= '0;
      ent1_q         <= '0;
      cnt_q          <= 2'd0;
      err_overflow_q <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      beat_cnt_q     <= beat_cnt_d;
      rd_bank_q      <= rd_bank_d;
      iss_bank_q     <= iss_bank_d;
      iss_busy_q     <= iss_busy_d;
      iss_addr_q     <= iss_addr_d;
      rd_vld_q       <= iss_en;
      if (iss_en) begin
        rd_user_q <= iss_addr_q;
      end
      ent0_q         <= ent0_d;
      ent1_q         <= ent1_d;
      cnt_q          <= cnt_d;
      err_overflow_q <= err_overflow_d;
      err_len_q      <= err_len_d;
    end
  end

  frame_bank_ram #(
    .AddrW(WIDTH + 1),
    .DataW(DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i({wr_bank_q, in_k}),
    .wdata_i(in_data),
    .re_i   (iss_en),
    .raddr_i({iss_bank_q, iss_addr_q}),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    frames_held = 2'd0;
    for (int b = 0; b < 2; b++) begin
      if (state_q[b] != BankEmpty) begin
        frames_held = frames_held + 2'd1;
      end
    end
  end

  assign in_ready     = (state_q[wr_bank_q] == BankEmpty);
  assign m_tvalid     = (cnt_q != 2'd0);
  assign m_tdata      = {ent0_q.data[ImMsb:ImLsb], ent0_q.data[ReMsb:ReLsb]};
  assign m_tuser      = ent0_q.user;
  assign m_tlast      = m_tvalid && ent0_q.last;
  assign err_overflow = err_overflow_q;
  assign err_len      = err_len_q;

endmodule

// File: tb/tb_ifft_frame_feeder.sv
// Self-checking bench for ifft_frame_feeder: frame model plus output scoreboard.
module tb_ifft_frame_feeder;

  localparam int W  = 11;
  localparam int N  = 2048;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [W-1:0]  in_k;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] m_tdata;
  logic [W-1:0]  m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [1:0]    frames_held;
  logic          err_overflow;
  logic          err_len;

  typedef logic [59:0] beat_t;

  beat_t         sb[$];
  logic [DW-1:0] model [2][N];
  bit            wr_bank_m;
  int            n_tests;
  int            n_fail;
  int            pops;
  int            idle;
  int            rdy_mode;

  ifft_frame_feeder #(.WIDTH(W), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_k        (in_k),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .frames_held (frames_held),
    .err_overflow(err_overflow),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int tag, input int k);
    logic [23:0] im;
    im = 24'(tag << 12) | 24'(k);
    return {im, ~im};
  endfunction

  // Ready pattern: 0 = stalled, 1 = always ready, otherwise random.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard compare on handshake, stability under stall.
  initial begin
    logic  prev_stall;
    logic [60:0] prev_out;
    beat_t exp;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_stable", 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'(prev_out));
        end
        if (m_tvalid && m_tready) begin
          check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("beat", 64'({m_tlast, m_tuser, m_tdata}), 64'(exp));
          end
          pops++;
        end else if (m_tready && !m_tvalid && sb.size() != 0) begin
          idle++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tvalid, m_tlast, m_tuser, m_tdata};
      end
    end
  end

  task automatic drive_frame(input int nbeats, input bit rev, input int tag, input bit chk_lat);
    int k;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk);
      #1;
      k        = rev ? (N - 1 - i) : i;
      in_valid = 1'b1;
      in_k     = W'(k);
      in_data  = mk_data(tag, k);
      in_last  = (i == nbeats - 1);
      model[wr_bank_m][k] = in_data;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int j = 0; j < N; j++) begin
      sb.push_back({(j == N - 1), W'(j), model[wr_bank_m][j]});
    end
    wr_bank_m = ~wr_bank_m;
    if (chk_lat) begin
      check("lat_edge0", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_edge1", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_edge2", 64'(m_tvalid), 64'd1);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || m_tvalid) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_drain_in_time"}, 64'(c < budget), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check(tag, 64'({in_ready, m_tvalid, m_tlast, m_tdata, m_tuser, frames_held, err_overflow,
                    err_len}), 64'({1'b1, 1'b0, 1'b0, 48'd0, 11'd0, 2'd0, 1'b0, 1'b0}));
  endtask

  initial begin
    int p0;
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
    p0 = 0;
  end

  initial begin
    int p0;
    n_tests   = 0;
    n_fail    = 0;
    pops      = 0;
    idle      = 0;
    rdy_mode  = 0;
    wr_bank_m = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        model[b][k] = '0;
      end
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_k     = '0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_values");
    rst      = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // Frame 0 in order, always ready.
    idle = 0;
    p0   = pops;
    drive_frame(N, 1'b0, 0, 1'b1);
    wait_drain("fwd", 5000);
    check("fwd_beats", 64'(pops - p0), 64'(N));
    check("fwd_no_gap", 64'(idle), 64'd2);
    check("fwd_in_ready", 64'(in_ready), 64'd1);
    check("fwd_held", 64'(frames_held), 64'd0);

    // Reverse bin order.
    idle = 0;
    p0   = pops;
    drive_frame(N, 1'b1, 1, 1'b1);
    wait_drain("rev", 5000);
    check("rev_beats", 64'(pops - p0), 64'(N));
    check("rev_no_gap", 64'(idle), 64'd2);
    check("rev_err_len", 64'(err_len), 64'd0);

    // Two frames against a stalled sink, then an overflow beat.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    drive_frame(N, 1'b0, 2, 1'b1);
    drive_frame(N, 1'b0, 3, 1'b0);
    check("b2b_in_ready", 64'(in_ready), 64'd0);
    check("b2b_held", 64'(frames_held), 64'd2);
    check("b2b_ovf_before", 64'(err_overflow), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_k     = W'(5);
    in_data  = 48'hBAD_BAD_BAD_BAD;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_ovf_after", 64'(err_overflow), 64'd1);
    check("b2b_held_after_ovf", 64'(frames_held), 64'd2);
    idle     = 0;
    p0       = pops;
    rdy_mode = 1;
    wait_drain("b2b", 20000);
    check("b2b_beats", 64'(pops - p0), 64'(2 * N));
    check("b2b_no_gap", 64'(idle), 64'd0);
    check("b2b_err_len", 64'(err_len), 64'd0);

    // Random backpressure during the drain.
    rdy_mode = 2;
    p0       = pops;
    drive_frame(N, 1'b0, 4, 1'b1);
    wait_drain("rnd", 20000);
    check("rnd_beats", 64'(pops - p0), 64'(N));

    // Short frame: flagged, still drained in full.
    rdy_mode = 1;
    p0       = pops;
    drive_frame(1000, 1'b0, 5, 1'b1);
    check("short_err_len", 64'(err_len), 64'd1);
    wait_drain("short", 5000);
    check("short_beats", 64'(pops - p0), 64'(N));

    // Asynchronous reset in the middle of a drain.
    drive_frame(N, 1'b0, 6, 1'b1);
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset("reset_mid_drain");
    sb.delete();
    wr_bank_m = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    idle = 0;
    p0   = pops;
    drive_frame(N, 1'b1, 7, 1'b1);
    wait_drain("post_rst", 5000);
    check("post_rst_beats", 64'(pops - p0), 64'(N));
    check("post_rst_no_gap", 64'(idle), 64'd2);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
